// File: rtl/coef_pack_pkg.sv
// Shared types and default sizing for the coefficient packing scheduler.
package coef_pack_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        CLEAR  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_DATA_WIDTH     = 12;
    localparam int DEF_COEF_PER_WORD  = 4;
    localparam int DEF_WORDS_PER_POLY = 64;
    localparam int COEF_PER_POLY      = DEF_COEF_PER_WORD * DEF_WORDS_PER_POLY;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, ascending with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      index
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        // Offsets start at 1 so the previous owner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IW-1:0]]    = 1'b1;
                index                = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/coef_pack_sched.sv
// Shares one coefficient packing buffer between NUM_REQ sources, one whole
// polynomial per grant, with buffer clear between polynomials.
module coef_pack_sched
    import coef_pack_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int COEF_PER_WORD  = DEF_COEF_PER_WORD,
    parameter int WORDS_PER_POLY = DEF_WORDS_PER_POLY,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_REQ-1:0]            src_valid,
    output logic [NUM_REQ-1:0]            src_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          buf_clr_n,
    output logic                          buf_w_en,
    output logic                          buf_valid_in,
    output logic [DATA_WIDTH-1:0]         buf_data_in,
    input  logic                          buf_full,
    input  logic                          buf_word_valid,
    output logic                          busy,
    output logic                          poly_done,
    output logic [IW-1:0]                 poly_owner,
    output logic                          protocol_err
);

    localparam int POLY_COEFS = COEF_PER_WORD * WORDS_PER_POLY;
    localparam int CW         = $clog2(POLY_COEFS) + 1;
    localparam int WW         = $clog2(WORDS_PER_POLY) + 1;

    localparam logic [CW-1:0] COEF_LAST = CW'(POLY_COEFS);
    localparam logic [CW-1:0] COEF_PRE  = CW'(POLY_COEFS - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_POLY);

    state_t               state, state_next;
    logic [IW-1:0]        last_grant;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic [CW-1:0]        coef_cnt;
    logic [WW-1:0]        word_cnt, word_cnt_next;
    logic                 ready_g;
    logic                 xfer;
    logic                 word_err;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (arb_gnt),
        .index      (arb_idx)
    );

    // Write side is a pure pass-through from the owning source.
    always_comb begin
        src_ready    = '0;
        buf_data_in  = '0;
        ready_g      = (state == STREAM) && !buf_full && (coef_cnt < COEF_LAST);
        xfer         = ready_g && src_valid[poly_owner];
        if (state == STREAM) begin
            src_ready[poly_owner] = ready_g;
            buf_data_in           = src_data[int'(poly_owner)*DATA_WIDTH +: DATA_WIDTH];
        end
        buf_w_en     = xfer;
        buf_valid_in = xfer;
    end

    always_comb begin
        word_cnt_next = word_cnt;
        if (buf_word_valid && (state == STREAM || state == DRAIN) && word_cnt < WORD_LAST)
            word_cnt_next = word_cnt + 1'b1;
        word_err = buf_word_valid &&
                   (state == IDLE || state == ARB || state == CLEAR || word_cnt == WORD_LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (|req) state_next = ARB;
            ARB:    state_next = (|req) ? CLEAR : IDLE;
            CLEAR:  state_next = STREAM;
            STREAM: if (coef_cnt == COEF_LAST || (xfer && coef_cnt == COEF_PRE))
                        state_next = DRAIN;
            DRAIN:  if (word_cnt_next == WORD_LAST) state_next = DONE;
            DONE:   state_next = (|req) ? ARB : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign poly_done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            poly_owner   <= '0;
            last_grant   <= IW'(NUM_REQ - 1);
            coef_cnt     <= '0;
            word_cnt     <= '0;
            buf_clr_n    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state     <= state_next;
            // Registered so the clear lands exactly on the CLEAR cycle.
            buf_clr_n <= (state_next != CLEAR);
            if (state == ARB && |req) begin
                grant      <= arb_gnt;
                poly_owner <= arb_idx;
                last_grant <= arb_idx;
            end
            if (state_next == DONE)
                grant <= '0;
            if (state == CLEAR) begin
                coef_cnt <= '0;
                word_cnt <= '0;
            end else begin
                if (xfer && coef_cnt < COEF_LAST)
                    coef_cnt <= coef_cnt + 1'b1;
                word_cnt <= word_cnt_next;
            end
            if (word_err)
                protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_coef_pack_sched.sv
// Directed bench for coef_pack_sched with a small packing-buffer stand-in.
module tb_coef_pack_sched;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [23:0] src_data;
    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic [1:0]  grant;
    logic        buf_clr_n;
    logic        buf_w_en;
    logic        buf_valid_in;
    logic [11:0] buf_data_in;
    logic        buf_full;
    logic        buf_word_valid;
    logic        busy;
    logic        poly_done;
    logic [0:0]  poly_owner;
    logic        protocol_err;

    int errors = 0;
    int checks = 0;

    coef_pack_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .grant          (grant),
        .buf_clr_n      (buf_clr_n),
        .buf_w_en       (buf_w_en),
        .buf_valid_in   (buf_valid_in),
        .buf_data_in    (buf_data_in),
        .buf_full       (buf_full),
        .buf_word_valid (buf_word_valid),
        .busy           (busy),
        .poly_done      (poly_done),
        .poly_owner     (poly_owner),
        .protocol_err   (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Streams one polynomial from source src; the bench plays the buffer,
    // emitting a word-valid pulse the cycle after every fourth write.
    task automatic stream_poly(input int src, input logic [1:0] req_start,
                               input logic [1:0] req_after, input int bp_at,
                               input int bp_len, input int drop_at,
                               input logic [1:0] req_drop, input string tag,
                               output int idle_cycles, output int first_rdy,
                               output int first_clr);
        int wr = 0, bad = 0, pend = 0, cyc = 0;
        int last_wv = -10, done_cyc = -1, bp_left = 0, bp_bad = 0;
        int other_rdy = 0, grant_bad = 0, vin_bad = 0;
        logic bp_started = 1'b0;
        logic [0:0] owner_seen = 1'b0;
        logic [1:0] grant_at_done = 2'b11;
        logic [1:0] own_mask;
        own_mask    = 2'b01 << src;
        idle_cycles = 0;
        first_rdy   = -1;
        first_clr   = -1;
        src_valid   = 2'b11;
        while (done_cyc < 0 && cyc < 3000) begin
            @(negedge clk);
            if (cyc == 0) req = req_start;
            if (drop_at >= 0 && wr == drop_at) req = req_drop;
            buf_word_valid = pend[0];
            pend = 0;
            if (buf_word_valid) last_wv = cyc;
            if (bp_len > 0 && !bp_started && wr == bp_at) begin
                bp_left    = bp_len;
                bp_started = 1'b1;
            end
            buf_full = (bp_left > 0);
            src_data = {12'hABC, 12'hABC};
            src_data[src*12 +: 12] = 12'(wr);
            #1;
            if (!busy) idle_cycles++;
            if (!buf_clr_n && first_clr < 0) first_clr = cyc;
            if ((src_ready & own_mask) != 0 && first_rdy < 0) first_rdy = cyc;
            if (bp_left > 0) begin
                if (src_ready != 2'b00 || buf_w_en) bp_bad++;
                bp_left--;
            end
            if ((src_ready & ~own_mask) != 0) other_rdy++;
            if (src_ready != 2'b00 && grant != own_mask) grant_bad++;
            if (buf_valid_in != buf_w_en) vin_bad++;
            if (buf_w_en) begin
                if (buf_data_in != 12'(wr)) bad++;
                wr++;
                if (wr % 4 == 0) pend = 1;
            end
            if (poly_done) begin
                done_cyc      = cyc;
                owner_seen    = poly_owner;
                grant_at_done = grant;
                req           = req_after;
            end
            cyc++;
        end
        buf_word_valid = 1'b0;
        buf_full       = 1'b0;

        checks++;
        if (wr !== 256) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected 256", tag, wr);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s write_data: %0d writes carried the wrong coefficient, expected 0", tag, bad);
        end
        checks++;
        if (other_rdy !== 0 || grant_bad !== 0 || vin_bad !== 0) begin
            errors++;
            $display("FAIL %s ownership: other_ready=%0d grant_bad=%0d valid_in_bad=%0d expected all 0",
                     tag, other_rdy, grant_bad, vin_bad);
        end
        if (bp_len > 0) begin
            checks++;
            if (bp_bad !== 0) begin
                errors++;
                $display("FAIL %s backpressure: %0d cycles with ready/write under full, expected 0", tag, bp_bad);
            end
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL %s poly_done: not seen within 3000 cycles, expected a pulse", tag);
        end else begin
            checks++;
            if (owner_seen !== 1'(src)) begin
                errors++;
                $display("FAIL %s poly_owner: got %0d expected %0d", tag, owner_seen, src);
            end
            checks++;
            if (done_cyc - last_wv !== 1) begin
                errors++;
                $display("FAIL %s done_latency: got %0d cycles after last word expected 1", tag, done_cyc - last_wv);
            end
            checks++;
            if (grant_at_done !== 2'b00) begin
                errors++;
                $display("FAIL %s grant_in_done: got %b expected 00", tag, grant_at_done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        req            = 2'b00;
        src_valid      = 2'b00;
        src_data       = '0;
        buf_full       = 1'b0;
        buf_word_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (grant !== 2'b00 || src_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_grant_ready: grant=%b ready=%b expected 00 00", grant, src_ready);
        end
        checks++;
        if (buf_clr_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_clr: buf_clr_n=%b expected 0", buf_clr_n);
        end
        checks++;
        if (buf_w_en !== 1'b0 || buf_valid_in !== 1'b0 || buf_data_in !== 12'd0) begin
            errors++;
            $display("FAIL reset_write: w_en=%b valid_in=%b data=%0d expected 0 0 0",
                     buf_w_en, buf_valid_in, buf_data_in);
        end
        checks++;
        if (busy !== 1'b0 || poly_done !== 1'b0 || poly_owner !== 1'b0 || protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b owner=%b err=%b expected 0 0 0 0",
                     busy, poly_done, poly_owner, protocol_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (buf_clr_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: buf_clr_n=%b busy=%b expected 1 0", buf_clr_n, busy);
        end
    endtask

    task automatic test_single_source();
        int idle_c, rdy_c, clr_c;
        stream_poly(0, 2'b01, 2'b00, -1, 0, -1, 2'b00, "single", idle_c, rdy_c, clr_c);
        checks++;
        if (clr_c !== 2 || rdy_c !== 3) begin
            errors++;
            $display("FAIL single_latency: clear at %0d ready at %0d expected 2 and 3", clr_c, rdy_c);
        end
    endtask

    task automatic test_back_to_back();
        int idle_c, rdy_c, clr_c;
        rst_n = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stream_poly(0, 2'b11, 2'b11, -1, 0, -1, 2'b11, "b2b_first", idle_c, rdy_c, clr_c);
        stream_poly(1, 2'b11, 2'b00, -1, 0, -1, 2'b11, "b2b_second", idle_c, rdy_c, clr_c);
        checks++;
        if (idle_c !== 0) begin
            errors++;
            $display("FAIL b2b_no_idle: %0d idle cycles between polynomials expected 0", idle_c);
        end
    endtask

    task automatic test_backpressure();
        int idle_c, rdy_c, clr_c;
        stream_poly(0, 2'b01, 2'b00, 100, 10, -1, 2'b01, "backpressure", idle_c, rdy_c, clr_c);
    endtask

    task automatic test_req_drop();
        int idle_c, rdy_c, clr_c;
        stream_poly(1, 2'b10, 2'b00, -1, 0, 50, 2'b00, "req_drop", idle_c, rdy_c, clr_c);
    endtask

    task automatic test_reset_mid_poly();
        int wr = 0, pend = 0, dones = 0;
        req       = 2'b01;
        src_valid = 2'b11;
        for (int c = 0; c < 400 && wr < 128; c++) begin
            @(negedge clk);
            buf_word_valid = pend[0];
            pend = 0;
            src_data = {12'hABC, 12'(wr)};
            #1;
            if (buf_w_en) begin
                wr++;
                if (wr % 4 == 0) pend = 1;
            end
        end
        checks++;
        if (wr !== 128) begin
            errors++;
            $display("FAIL midreset_reach: got %0d writes expected 128", wr);
        end
        @(negedge clk);
        buf_word_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || buf_clr_n !== 1'b0 || src_ready !== 2'b00) begin
            errors++;
            $display("FAIL midreset_immediate: grant=%b busy=%b clr_n=%b ready=%b expected 00 0 0 00",
                     grant, busy, buf_clr_n, src_ready);
        end
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #1;
            if (poly_done) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_done: done pulses=%0d busy=%b expected 0 0", dones, busy);
        end
    endtask

    task automatic test_protocol_err();
        int idle_c, rdy_c, clr_c;
        @(negedge clk);
        #1;
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL perr_initial: got %b expected 0", protocol_err);
        end
        @(negedge clk);
        buf_word_valid = 1'b1;
        @(negedge clk);
        buf_word_valid = 1'b0;
        #1;
        checks++;
        if (protocol_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL perr_idle_word: err=%b busy=%b expected 1 0", protocol_err, busy);
        end
        stream_poly(0, 2'b01, 2'b00, -1, 0, -1, 2'b01, "after_err", idle_c, rdy_c, clr_c);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky: got %b expected 1", protocol_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_back_to_back();
        test_backpressure();
        test_req_drop();
        test_reset_mid_poly();
        test_protocol_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coef_pack_sched.md
Name: coef_pack_sched

Overview:
- Round-robin scheduler that shares one 12-bit-to-48-bit coefficient packing buffer between NUM_REQ coefficient sources.
- Grants the buffer to one source for one whole polynomial of 256 coefficients, which the buffer emits as 64 words.
- Drives the buffer write side, counts emitted words, clears the buffer between polynomials and pulses completion to the hash datapath.

Parameters:
- NUM_REQ, 2, number of coefficient sources (2..8).
- DATA_WIDTH, 12, coefficient width.
- COEF_PER_WORD, 4, coefficients packed per buffer output word.
- WORDS_PER_POLY, 64, buffer output words per polynomial.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-source request for the buffer; level-sensitive.
- src_data  in  NUM_REQ*DATA_WIDTH  source coefficients; source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- src_valid  in  NUM_REQ  per-source coefficient valid.
- src_ready  out  NUM_REQ  per-source ready; a transfer occurs when valid and ready are both high.
- grant  out  NUM_REQ  one-hot owner of the buffer; all zero when idle.
- buf_clr_n  out  1  synchronous clear to the buffer's rst_n input; active low.
- buf_w_en  out  1  buffer write enable.
- buf_valid_in  out  1  buffer data valid.
- buf_data_in  out  DATA_WIDTH  coefficient forwarded to the buffer.
- buf_full  in  1  buffer full flag.
- buf_word_valid  in  1  buffer valid_out; one pulse per packed 48-bit word.
- busy  out  1  high in every state except IDLE.
- poly_done  out  1  single-cycle pulse when a polynomial has fully drained.
- poly_owner  out  $clog2(NUM_REQ) or 1 bit minimum  index of the source that owned the polynomial; valid with poly_done.
- protocol_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset is asynchronous on rst_n low and releases synchronously to clk. Reset values:
  - state = IDLE.
  - grant = 0, src_ready = 0.
  - buf_clr_n = 0, held low during reset so the buffer is also cleared.
  - buf_w_en = 0, buf_valid_in = 0, buf_data_in = 0.
  - busy = 0, poly_done = 0, poly_owner = 0, protocol_err = 0.
  - coef_cnt = 0, word_cnt = 0.
  - last_grant = NUM_REQ-1, so source 0 wins first.
- Outside CLEAR and reset, buf_clr_n = 1.
- Counters:
  - coef_cnt is $clog2(COEF_PER_WORD*WORDS_PER_POLY)+1 bits (9 bits at defaults).
  - word_cnt is $clog2(WORDS_PER_POLY)+1 bits (7 bits at defaults).
  - Neither counter wraps; each saturates at its terminal value.
- FSM states:
  - IDLE: when |req, go to ARB.
  - ARB (1 cycle): round-robin pick of the first requesting source after last_grant, in ascending index order with wrap. Register grant (one-hot), poly_owner and last_grant. Go to CLEAR.
    - If req has dropped to zero in this cycle: return to IDLE with no grant.
  - CLEAR (1 cycle): buf_clr_n = 0. Zero coef_cnt and word_cnt. Go to STREAM.
  - STREAM:
    - Only the granted source can see ready: src_ready[g] = !buf_full && (coef_cnt < 256). All other src_ready bits are 0.
    - buf_w_en = buf_valid_in = src_valid[g] && src_ready[g]; buf_data_in = slice g of src_data. This path is combinational, with zero added latency.
    - Each transfer increments coef_cnt.
    - When coef_cnt reaches 256, go to DRAIN.
  - DRAIN: src_ready = 0. Wait until word_cnt == 64, then go to DONE.
  - DONE (1 cycle): poly_done = 1 and grant cleared. Go to ARB if |req, otherwise to IDLE.
- word_cnt increments on buf_word_valid in STREAM and DRAIN.
- Error cases; each sets protocol_err and leaves the FSM unaffected:
  - buf_word_valid in IDLE, ARB or CLEAR.
  - Any buf_word_valid beyond 64 words.
- Grant is non-preemptive: once issued, it holds until DONE, even if req[g] drops mid-polynomial. Data from non-granted sources is ignored.
- Simultaneous req and DONE: the next arbitration excludes nothing; round-robin fairness comes from last_grant alone.
- buf_full in STREAM: src_ready drops combinationally and no write is issued in that cycle.
- Reset mid-operation: everything returns to reset values immediately; the partial polynomial is discarded and poly_done is not issued.
- Latency: req seen in IDLE at cycle t → grant at t+1 (ARB) → buf_clr_n low during t+2 (CLEAR) → first src_ready possible at t+3.

Decomposition:
- Package coef_pack_pkg holds:
  - state enum {IDLE, ARB, CLEAR, STREAM, DRAIN, DONE}, 3-bit encoding.
  - COEF_PER_POLY = COEF_PER_WORD*WORDS_PER_POLY.
  - Default widths.
- One sub-module, rr_arbiter, parameterised by NUM_REQ:
  - Inputs: req, last_grant.
  - Outputs: one-hot gnt and an index.
  - Purely combinational; the top module registers its outputs in ARB.

Test Plan:
- Single source, no backpressure: req[0]=1, src_valid[0] streams 256 coefficients 0..255. Expect:
  - grant = 2'b01 throughout.
  - Exactly 256 buf_w_en pulses with buf_data_in = 0..255.
  - poly_done one cycle after the 64th buf_word_valid, with poly_owner = 0.
- Both sources request after reset: req = 2'b11. Expect source 0 to own the first polynomial and source 1 the second, with poly_owner sequence 0, 1 and no IDLE state between them.
- Backpressure: hold buf_full = 1 for 10 cycles mid-stream at coef_cnt = 100. Expect src_ready[g] = 0 and no writes during those cycles, then a resume with the total still exactly 256.
- Request drop: req[1] falls at coef_cnt = 50. Expect grant[1] to stay high and the polynomial to complete with poly_done.
- Reset mid-polynomial: pull rst_n low at coef_cnt = 128. Expect, in the same cycle:
  - grant = 0, busy = 0, buf_clr_n = 0.
  - No poly_done afterwards.
- Protocol error: pulse buf_word_valid in IDLE. Expect protocol_err = 1, held until reset, with subsequent polynomials still completing normally.
